// File: rtl/csa_acc.sv
// Frame accumulator: carry-save compression of incoming samples, one-cycle
// carry-propagate resolve, held result. Optional saturation via CSA_ACC_SAT_EN.
module csa_acc #(
  parameter int IN_W  = 5,
  parameter int CNT_W = 4,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [CNT_W-1:0] len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int TW = IN_W + CNT_W;
  localparam logic [TW-1:0]  ACC_MAX = {TW{1'b1}} >> (TW - ACC_W);
  localparam logic [CNT_W:0] CNT_ONE = {{CNT_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACC     = 2'd1,
    RESOLVE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t state_r, state_s;

  logic [TW-1:0]    sum_r, carry_r, total_r;
  logic [CNT_W:0]   cnt_r, len_r;
  logic             out_valid_r, out_ovf_r;
  logic [ACC_W-1:0] out_sum_r;

  logic             accept_s;
  logic [CNT_W:0]   len_eff_s, cnt_inc_s;
  logic [TW-1:0]    x_s, csa_sum_s, csa_carry_s;
  logic [TW-2:0]    maj_s;
  logic             ovf_s;
  logic [ACC_W-1:0] res_s;

  assign accept_s  = in_valid & in_ready;
  // A zero length encodes the maximum frame of 2^CNT_W samples.
  assign len_eff_s = (len == {CNT_W{1'b0}}) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, len};
  assign cnt_inc_s = cnt_r + CNT_ONE;
  assign x_s       = {{CNT_W{1'b0}}, in_data};

  // 3:2 compressor; the carry MSB is dropped since the exact total fits TW bits.
  assign csa_sum_s   = sum_r ^ carry_r ^ x_s;
  assign maj_s       = (sum_r[TW-2:0] & carry_r[TW-2:0]) |
                       (sum_r[TW-2:0] & x_s[TW-2:0]) |
                       (carry_r[TW-2:0] & x_s[TW-2:0]);
  assign csa_carry_s = {maj_s, 1'b0};

  assign ovf_s = (total_r > ACC_MAX);
`ifdef CSA_ACC_SAT_EN
  assign res_s = ovf_s ? {ACC_W{1'b1}} : total_r[ACC_W-1:0];
`else
  assign res_s = total_r[ACC_W-1:0];
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = (len_eff_s == CNT_ONE) ? RESOLVE : ACC;
        end else begin
          state_s = IDLE;
        end
      end
      ACC: begin
        if (accept_s && (cnt_inc_s == len_r)) begin
          state_s = RESOLVE;
        end else begin
          state_s = ACC;
        end
      end
      RESOLVE: state_s = HOLD;
      HOLD: begin
        if (out_valid_r && out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    in_ready  = ~rst & ((state_r == IDLE) | (state_r == ACC));
    out_valid = out_valid_r;
    out_sum   = out_sum_r;
    out_ovf   = out_ovf_r;
  end

  // Datapath: redundant accumulation, resolve, and held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_r       <= {TW{1'b0}};
      carry_r     <= {TW{1'b0}};
      total_r     <= {TW{1'b0}};
      cnt_r       <= {(CNT_W+1){1'b0}};
      len_r       <= {(CNT_W+1){1'b0}};
      out_valid_r <= 1'b0;
      out_sum_r   <= {ACC_W{1'b0}};
      out_ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            len_r   <= len_eff_s;
            sum_r   <= x_s;
            carry_r <= {TW{1'b0}};
            cnt_r   <= CNT_ONE;
          end
        end
        ACC: begin
          if (accept_s) begin
            sum_r   <= csa_sum_s;
            carry_r <= csa_carry_s;
            cnt_r   <= cnt_inc_s;
          end
        end
        RESOLVE: total_r <= sum_r + carry_r;
        HOLD: begin
          // First HOLD cycle publishes the result; it is then held until taken.
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
            out_sum_r   <= res_s;
            out_ovf_r   <= ovf_s;
          end else if (out_ready) begin
            out_valid_r <= 1'b0;
            sum_r       <= {TW{1'b0}};
            carry_r     <= {TW{1'b0}};
            cnt_r       <= {(CNT_W+1){1'b0}};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_acc.sv
// Self-checking bench for csa_acc: directed frames plus randomized frames
// checked against a plain-arithmetic frame-sum model.
module tb_csa_acc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] in_data = 5'd0;
  logic [3:0] len = 4'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_sum;
  logic       out_ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int smp [0:15];

  csa_acc dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .len(len), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: frame total, then wrap or saturate to 8 bits.
  function automatic int model_sum(input int total);
`ifdef CSA_ACC_SAT_EN
    return (total > 255) ? 255 : total;
`else
    return total % 256;
`endif
  endfunction

  // Present one sample and hold it until the block takes it (bounded).
  task automatic send(input int d, input string nm);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = d[4:0];
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    n_checks++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL %s accept timeout in_ready=%0b required 1", nm, in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Wait for a result with out_ready high, check it and the handshake after.
  task automatic get_result(input int total, input string nm);
    int waited = 0;
    out_ready = 1'b1;
    while (!out_valid && waited < 50) begin
      tick();
      waited++;
    end
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s result timeout out_valid=%0b required 1", nm, out_valid);
    end
    n_checks++;
    if (out_sum !== model_sum(total)) begin
      n_fail++;
      $display("FAIL %s out_sum got %0d required %0d", nm, out_sum, model_sum(total));
    end
    n_checks++;
    if (out_ovf !== (total > 255)) begin
      n_fail++;
      $display("FAIL %s out_ovf got %0b required %0b", nm, out_ovf, total > 255);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s after consume out_valid=%0b in_ready=%0b required 0/1", nm, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_ready got %0b required 0", in_ready);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || out_sum !== 8'd0 || out_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got v=%0b s=%0d o=%0b required 0/0/0", out_valid, out_sum, out_ovf);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_in_ready got %0b required 1", in_ready);
    end
  endtask

  task automatic test_basic_latency();
    int vals [4] = '{5, 10, 15, 20};
    out_ready = 1'b1;
    len = 4'd4;
    foreach (vals[i]) send(vals[i], "basic");
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_lat_k got out_valid=%0b required 0", out_valid);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_lat_k1 got out_valid=%0b required 0", out_valid);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_sum !== 8'd50 || out_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_lat_k2 got v=%0b s=%0d o=%0b required 1/50/0", out_valid, out_sum, out_ovf);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_one_cycle got v=%0b rdy=%0b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_full_frame();
    len = 4'd0;
    for (int i = 0; i < 16; i++) send(31, "full");
    get_result(496, "full");
  endtask

  task automatic test_gaps();
    int vals [3] = '{7, 0, 9};
    len = 4'd3;
    foreach (vals[i]) begin
      send(vals[i], "gaps");
      repeat ($urandom_range(1, 3)) tick();
    end
    get_result(16, "gaps");
  endtask

  task automatic test_backpressure();
    int waited = 0;
    logic [7:0] s0;
    logic o0;
    out_ready = 1'b0;
    len = 4'd2;
    send(20, "bp");
    send(30, "bp");
    while (!out_valid && waited < 20) begin
      tick();
      waited++;
    end
    s0 = out_sum;
    o0 = out_ovf;
    n_checks++;
    if (out_valid !== 1'b1 || s0 !== 8'd50) begin
      n_fail++;
      $display("FAIL bp_result got v=%0b s=%0d required 1/50", out_valid, s0);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_sum !== s0 || out_ovf !== o0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold cyc%0d got v=%0b s=%0d o=%0b rdy=%0b required 1/%0d/%0b/0",
                 i, out_valid, out_sum, out_ovf, in_ready, s0, o0);
      end
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_consume got v=%0b rdy=%0b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_abort();
    len = 4'd4;
    send(9, "abort");
    send(11, "abort");
    rst = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_rst_ready got %0b required 0", in_ready);
    end
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_after_rst got v=%0b rdy=%0b required 0/1", out_valid, in_ready);
    end
    len = 4'd2;
    send(3, "abort");
    send(4, "abort");
    get_result(7, "abort");
  endtask

  task automatic test_len_change();
    len = 4'd2;
    send(6, "lenchg");
    len = 4'd1;
    send(6, "lenchg");
    get_result(12, "lenchg");
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      int n = $urandom_range(1, 16);
      int total = 0;
      len = n[3:0];
      for (int i = 0; i < n; i++) begin
        smp[i] = $urandom_range(0, 31);
        total += smp[i];
      end
      for (int i = 0; i < n; i++) begin
        send(smp[i], "random");
        if ($urandom_range(0, 3) == 0) tick();
      end
      get_result(total, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_full_frame();
    test_gaps();
    test_backpressure();
    test_abort();
    test_len_change();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/csa_acc.md
CSA_ACC -- requirements
Module: csa_acc

Interface
REQ-001 Parameter IN_W, 5, width of each incoming CSA result sample.
REQ-002 Parameter CNT_W, 4, width of the frame-length input; the maximum frame is 2^CNT_W samples.
REQ-003 Parameter ACC_W, 8, width of the reported sum; SHALL satisfy ACC_W <= IN_W+CNT_W.
REQ-004 clk  in  1  sole clock; all state SHALL update on rising edge.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 in_valid  in  1  in_data holds a valid CSA result.
REQ-007 in_ready  out  1  block accepts a sample this cycle.
REQ-008 in_data  in  IN_W  unsigned sample from the CSA stage.
REQ-009 len  in  CNT_W  frame length in samples; 0 means 2^CNT_W.
REQ-010 out_valid  out  1  out_sum/out_ovf hold a completed frame result.
REQ-011 out_ready  in  1  downstream accepts the result.
REQ-012 out_sum  out  ACC_W  frame total (wrapped or saturated; see Configuration).
REQ-013 out_ovf  out  1  frame total exceeded 2^ACC_W-1.

Function
REQ-014 A sample is accepted on a rising edge where in_valid and in_ready are both 1.
REQ-015 FSM states SHALL be IDLE, ACC, RESOLVE, HOLD.
REQ-016 in_ready SHALL be 1 in IDLE and ACC and 0 in RESOLVE and HOLD; out_valid SHALL be 1 only in HOLD.
REQ-017 IDLE: an accept latches len, loads the first sample, and moves to ACC, or to RESOLVE if the latched length is 1.
REQ-018 A change in len after the first accept of a frame SHALL have no effect on that frame.
REQ-019 ACC: each accept SHALL compress the sample into redundant sum/carry registers of width IN_W+CNT_W through a 3:2 carry-save stage, with no carry propagation.
REQ-020 ACC: the accept that completes the latched count SHALL move the FSM to RESOLVE; cycles with in_valid=0 SHALL hold all state.
REQ-021 RESOLVE SHALL last exactly one cycle, add sum+carry with a carry-propagate adder into the total, compute out_sum/out_ovf, and move to HOLD.
REQ-022 Latency: if the last sample is accepted at edge k, out_valid SHALL rise after edge k+2.
REQ-023 HOLD: out_valid, out_sum and out_ovf SHALL stay stable until out_ready=1, then move to IDLE on that edge.
REQ-024 out_ovf = 1 if and only if the resolved total > 2^ACC_W-1; the internal width SHALL make the total exact for 2^CNT_W samples of 2^IN_W-1.
REQ-025 After the HOLD-to-IDLE edge, in_ready SHALL be 1 on the next cycle; a new frame SHALL start with the redundant registers cleared.

Reset
REQ-026 rst=1 at a rising edge SHALL force IDLE, clear the sum, carry and count registers, and set out_valid=0, out_sum=0, out_ovf=0.
REQ-027 While rst=1, in_ready SHALL be 0; the first cycle after rst falls, in_ready SHALL be 1.
REQ-028 A reset during ACC, RESOLVE or HOLD SHALL discard the partial or pending frame without emitting it.

Configuration
REQ-029 Macro CSA_ACC_SAT_EN defined: on overflow, out_sum SHALL equal 2^ACC_W-1 (all ones).
REQ-030 Macro CSA_ACC_SAT_EN undefined: out_sum SHALL equal total mod 2^ACC_W.
REQ-031 out_ovf behaviour SHALL be identical with and without CSA_ACC_SAT_EN.

Verification
REQ-032 len=4, samples 5,10,15,20 accepted back-to-back, out_ready=1 -> out_sum=50, out_ovf=0, out_valid high exactly 2 cycles after the 4th accept, for 1 cycle.
REQ-033 len=0, sixteen samples of 31 -> total 496, out_ovf=1; out_sum=240 without CSA_ACC_SAT_EN, 255 with it.
REQ-034 len=3, samples 7,0,9 with 1-3 idle in_valid=0 cycles between them -> out_sum=16; no extra or lost accepts.
REQ-035 Frame done with out_ready=0 for 5 cycles -> out_valid/out_sum/out_ovf stable and in_ready=0 throughout; result consumed on the first out_ready=1 edge, in_ready=1 next cycle.
REQ-036 len=4, accept 2 samples, pulse rst for 1 cycle, then len=2 with samples 3,4 -> single result out_sum=7; no output for the aborted frame.
REQ-037 len=2 at the first accept, len changed to 1 before the second accept, samples 6,6 -> out_sum=12 after the second sample.
